// File: rtl/seq_arith_unit_if.sv
// seq_arith_unit_if: start/busy/done request bus between controller and the arithmetic engine
interface seq_arith_unit_if #(parameter int N = 16);
  logic         start;
  logic         mode;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] res;
  logic         ovf;
  modport master (output start, mode, a, b, input busy, done, res, ovf);
  modport slave  (input start, mode, a, b, output busy, done, res, ovf);
endinterface

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: iterative GCF / factorial engine with overflow saturation and start/busy/done handshake
module seq_arith_unit #(
  parameter int N = 16
) (
  input logic            clk,
  input logic            rst,
  seq_arith_unit_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_GCF, S_FACT, S_DONE} state_t;
  state_t         r_state, w_next;
  logic [N-1:0]   r_x, r_y, r_n, r_acc, r_res;
  logic [N:0]     r_i;
  logic           r_ovf, r_done;
  logic [2*N-1:0] w_p;
  logic           w_igt, w_hi, w_gcf_end;
  // i never exceeds n+1 while multiplying, so its low N bits carry the full factor
  assign w_p       = {{N{1'b0}}, r_acc} * {{N{1'b0}}, r_i[N-1:0]};
  assign w_igt     = r_i > {1'b0, r_n};
  assign w_hi      = |w_p[2*N-1:N];
  assign w_gcf_end = (r_y == '0) || (r_x == '0) || (r_x == r_y);
  assign bus.busy  = r_state != S_IDLE;
  assign bus.done  = r_done;
  assign bus.res   = r_res;
  assign bus.ovf   = r_ovf;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  // next-state: one GCF subtract or one factorial multiply per cycle until a terminal condition
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = bus.start ? (bus.mode ? S_FACT : S_GCF) : S_IDLE;
      S_GCF:   w_next = w_gcf_end ? S_DONE : S_GCF;
      S_FACT:  w_next = (w_igt || w_hi) ? S_DONE : S_FACT;
      default: w_next = S_IDLE;
    endcase
  end
  // datapath: operand capture on accept, iteration steps, registered result and done pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_n    <= '0;
      r_acc  <= '0;
      r_i    <= '0;
      r_res  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= r_state == S_DONE;
      case (r_state)
        S_IDLE:
          if (bus.start) begin
            r_x   <= bus.a;
            r_y   <= bus.b;
            r_n   <= bus.a;
            r_acc <= N'(1);
            r_i   <= (N+1)'(1);
            r_ovf <= 1'b0;
          end
        S_GCF:
          if (r_y == '0)       r_res <= r_x;
          else if (r_x == '0)  r_res <= r_y;
          else if (r_x == r_y) r_res <= r_x;
          else if (r_x > r_y)  r_x   <= r_x - r_y;
          else                 r_y   <= r_y - r_x;
        S_FACT:
          if (w_igt) r_res <= r_acc;
          else if (w_hi) begin
            r_ovf <= 1'b1;
            r_res <= '1;
          end else begin
            r_acc <= w_p[N-1:0];
            r_i   <= r_i + 1'b1;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit: directed and randomized checks of seq_arith_unit against a behavioural model
module tb_seq_arith_unit;
  localparam int N = 16;
  localparam int BUDGET = 5000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  seq_arith_unit_if #(.N(N)) bus();
  seq_arith_unit #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [N-1:0] gcf_ref(input logic [N-1:0] av, input logic [N-1:0] bv);
    longint x = av;
    longint y = bv;
    longint t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return N'(x);
  endfunction

  task automatic fact_ref(input logic [N-1:0] nv, output logic [N-1:0] r, output logic o, output int lat);
    longint prod = 1;
    o = 1'b0;
    for (int k = 1; k <= int'(nv); k++) begin
      prod = prod * k;
      if (prod >= (longint'(1) << N)) begin
        o = 1'b1;
        r = '1;
        lat = k + 1;
        return;
      end
    end
    r = N'(prod);
    lat = int'(nv) + 2;
  endtask

  task automatic run_op(input logic m, input logic [N-1:0] av, input logic [N-1:0] bv,
                        output int lat, output logic [N-1:0] r, output logic o, output int pulses);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = m;
    bus.a = av;
    bus.b = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mode = ~m;
    bus.a = N'($urandom);
    bus.b = N'($urandom);
    lat = -1;
    r = '0;
    o = 1'b0;
    pulses = 0;
    for (int e = 1; e <= BUDGET && (lat < 0 || e <= lat + 3); e++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = e;
          r = bus.res;
          o = bus.ovf;
        end
      end
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.res, bus.ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_state busy/done/res/ovf got %b/%b/%0h/%b exp 0/0/0/0", bus.busy, bus.done, bus.res, bus.ovf);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_gcf;
    int lat, p;
    logic [N-1:0] r;
    logic o;
    run_op(1'b0, 16'd12, 16'd8, lat, r, o, p);
    vectors++;
    if ({r, o} !== {16'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL gcf_12_8 res/ovf got %0d/%b exp 4/0", r, o);
    end
    vectors++;
    if ({lat, p} !== {32'd4, 32'd1}) begin
      miscompares++;
      $display("FAIL gcf_12_8_timing lat/pulses got %0d/%0d exp 4/1", lat, p);
    end
    run_op(1'b0, 16'd17, 16'd5, lat, r, o, p);
    vectors++;
    if ({r, o} !== {16'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL gcf_17_5 res/ovf got %0d/%b exp 1/0", r, o);
    end
  endtask

  task automatic test_gcf_edges;
    int lat, p;
    logic [N-1:0] r;
    logic o;
    run_op(1'b0, 16'd0, 16'd9, lat, r, o, p);
    vectors++;
    if ({r, o, lat} !== {16'd9, 1'b0, 32'd2}) begin
      miscompares++;
      $display("FAIL gcf_0_9 res/ovf/lat got %0d/%b/%0d exp 9/0/2", r, o, lat);
    end
    run_op(1'b0, 16'd0, 16'd0, lat, r, o, p);
    vectors++;
    if ({r, o, lat} !== {16'd0, 1'b0, 32'd2}) begin
      miscompares++;
      $display("FAIL gcf_0_0 res/ovf/lat got %0d/%b/%0d exp 0/0/2", r, o, lat);
    end
    run_op(1'b0, 16'd7, 16'd7, lat, r, o, p);
    vectors++;
    if ({r, o, lat} !== {16'd7, 1'b0, 32'd2}) begin
      miscompares++;
      $display("FAIL gcf_7_7 res/ovf/lat got %0d/%b/%0d exp 7/0/2", r, o, lat);
    end
  endtask

  task automatic test_fact;
    int lat, p;
    logic [N-1:0] r;
    logic o;
    run_op(1'b1, 16'd0, 16'd0, lat, r, o, p);
    vectors++;
    if ({r, o, lat} !== {16'd1, 1'b0, 32'd2}) begin
      miscompares++;
      $display("FAIL fact_0 res/ovf/lat got %0d/%b/%0d exp 1/0/2", r, o, lat);
    end
    run_op(1'b1, 16'd5, 16'd3, lat, r, o, p);
    vectors++;
    if ({r, o, lat} !== {16'd120, 1'b0, 32'd7}) begin
      miscompares++;
      $display("FAIL fact_5 res/ovf/lat got %0d/%b/%0d exp 120/0/7", r, o, lat);
    end
    run_op(1'b1, 16'd8, 16'd0, lat, r, o, p);
    vectors++;
    if ({r, o, lat} !== {16'd40320, 1'b0, 32'd10}) begin
      miscompares++;
      $display("FAIL fact_8 res/ovf/lat got %0d/%b/%0d exp 40320/0/10", r, o, lat);
    end
  endtask

  task automatic test_fact_ovf;
    int lat, p;
    logic [N-1:0] r;
    logic o;
    run_op(1'b1, 16'd9, 16'd0, lat, r, o, p);
    vectors++;
    if ({r, o, lat} !== {16'hFFFF, 1'b1, 32'd10}) begin
      miscompares++;
      $display("FAIL fact_9_ovf res/ovf/lat got %0h/%b/%0d exp ffff/1/10", r, o, lat);
    end
    run_op(1'b1, 16'd3, 16'd0, lat, r, o, p);
    vectors++;
    if ({r, o, lat} !== {16'd6, 1'b0, 32'd5}) begin
      miscompares++;
      $display("FAIL fact_3_after_ovf res/ovf/lat got %0d/%b/%0d exp 6/0/5", r, o, lat);
    end
  endtask

  task automatic test_handshake;
    int first = -1;
    int pulses = 0;
    logic [N-1:0] held = '0;
    logic held_ok = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 1'b0;
    bus.a = 16'd12;
    bus.b = 16'd8;
    @(posedge clk);
    #1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      bus.start = (e == 1 || e == 4);
      bus.mode = 1'b1;
      bus.a = 16'd6;
      bus.b = 16'd100;
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = e;
          held = bus.res;
        end
      end
      if (first >= 0 && e > first && bus.res !== held) held_ok = 1'b0;
    end
    vectors++;
    if ({first, pulses} !== {32'd4, 32'd1}) begin
      miscompares++;
      $display("FAIL handshake_pulses first_done/pulses got %0d/%0d exp 4/1", first, pulses);
    end
    vectors++;
    if ({held, held_ok, bus.busy} !== {16'd4, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL handshake_hold res/held/busy got %0d/%b/%b exp 4/1/0", held, held_ok, bus.busy);
    end
  endtask

  task automatic test_back_to_back;
    int e1 = -1;
    int e2 = -1;
    logic [N-1:0] r1 = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 1'b1;
    bus.a = 16'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int e = 1; e <= 20 && e1 < 0; e++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        e1 = e;
        r1 = bus.res;
      end
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 1'b0;
    bus.a = 16'd7;
    bus.b = 16'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int e = 1; e <= 20 && e2 < 0; e++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) e2 = e;
    end
    vectors++;
    if ({e1, r1} !== {32'd5, 16'd6}) begin
      miscompares++;
      $display("FAIL b2b_first lat/res got %0d/%0d exp 5/6", e1, r1);
    end
    vectors++;
    if ({e2, bus.res} !== {32'd2, 16'd7}) begin
      miscompares++;
      $display("FAIL b2b_second lat/res got %0d/%0d exp 2/7", e2, bus.res);
    end
  endtask

  task automatic test_reset_mid_op;
    int lat, p;
    logic [N-1:0] r;
    logic o;
    logic was_busy;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 1'b0;
    bus.a = 16'd1000;
    bus.b = 16'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    was_busy = bus.busy;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({was_busy, bus.busy, bus.done, bus.res, bus.ovf} !== {1'b1, 19'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_op before_busy/busy/done/res/ovf got %b/%b/%b/%0h/%b exp 1/0/0/0/0",
               was_busy, bus.busy, bus.done, bus.res, bus.ovf);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 16'd9, 16'd6, lat, r, o, p);
    vectors++;
    if ({r, o, p} !== {16'd3, 1'b0, 32'd1}) begin
      miscompares++;
      $display("FAIL gcf_9_6_after_reset res/ovf/pulses got %0d/%b/%0d exp 3/0/1", r, o, p);
    end
  endtask

  task automatic test_random;
    int lat, p, elat;
    logic [N-1:0] r, er, av, bv;
    logic o, eo, m;
    for (int t = 0; t < 30; t++) begin
      m = 1'($urandom);
      av = m ? N'($urandom_range(0, 12)) : N'($urandom_range(0, 3000));
      bv = N'($urandom_range(0, 3000));
      if (m) fact_ref(av, er, eo, elat);
      else begin
        er = gcf_ref(av, bv);
        eo = 1'b0;
        elat = -1;
      end
      run_op(m, av, bv, lat, r, o, p);
      vectors++;
      if ({r, o} !== {er, eo} || p != 1 || lat < 0 || (m && lat != elat)) begin
        miscompares++;
        $display("FAIL random mode=%b a=%0d b=%0d res/ovf/lat/pulses got %0d/%b/%0d/%0d exp %0d/%b/%0d/1",
                 m, av, bv, r, o, lat, p, er, eo, elat);
      end
    end
  endtask

  initial begin
    test_reset;
    test_gcf;
    test_gcf_edges;
    test_fact;
    test_fact_ovf;
    test_handshake;
    test_back_to_back;
    test_reset_mid_op;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
